// File: rtl/decomp_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : decomp_ctrl
// Brief   : Fetches run-length tokens, feeds a bit-serial decompressor and
//           writes the finished words to a destination buffer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module decomp_ctrl #(
  parameter  int N  = 32,
  parameter  int AW = 16,
  localparam int VW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go_i,
  input  logic [AW-1:0] src_base_i,
  input  logic [AW-1:0] dst_base_i,
  input  logic [AW-1:0] word_count_i,
  output logic          tok_rd_o,
  output logic [AW-1:0] tok_addr_o,
  input  logic          tok_valid_i,
  input  logic [VW:0]   tok_data_i,
  output logic          dec_rst_o,
  output logic          dec_start_o,
  output logic          dec_bit_o,
  output logic [VW-1:0] dec_value_o,
  input  logic          dec_store_i,
  input  logic [N-1:0]  dec_out_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [N-1:0]  wr_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [VW-1:0] C_MAX_RUN = VW'(N);

  logic [2:0]    state_q,   state_d;
  logic [AW-1:0] src_q,     src_d;
  logic [AW-1:0] dst_q,     dst_d;
  logic [AW-1:0] cnt_q,     cnt_d;
  logic [AW-1:0] tok_idx_q, tok_idx_d;
  logic [AW-1:0] words_q,   words_d;
  logic          err_q,     err_d;
  logic          tbit_q,    tbit_d;
  logic [VW-1:0] tlen_q,    tlen_d;

  logic          busy_w;
  logic          wr_w;
  logic [VW-1:0] in_len_w;

  assign busy_w   = (state_q != S_IDLE);
  // A store beyond the requested word count is a leftover and is dropped.
  assign wr_w     = busy_w && dec_store_i && (words_q != cnt_q);
  assign in_len_w = tok_data_i[VW-1:0];

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    tok_idx_d = tok_idx_q;
    words_d   = words_q;
    err_d     = err_q;
    tbit_d    = tbit_q;
    tlen_d    = tlen_q;

    if (wr_w) begin
      words_d = words_q + AW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          src_d     = src_base_i;
          dst_d     = dst_base_i;
          cnt_d     = word_count_i;
          tok_idx_d = '0;
          words_d   = '0;
          err_d     = 1'b0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = (cnt_q == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        tok_idx_d = tok_idx_q + AW'(1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (tok_valid_i) begin
          tbit_d = tok_data_i[VW];
          tlen_d = in_len_w;
          if (in_len_w == '0) begin
            state_d = S_FETCH;
          end else if (in_len_w > C_MAX_RUN) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // words_d already includes a store landing in this cycle.
        state_d = (words_d == cnt_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      tok_idx_q <= '0;
      words_q   <= '0;
      err_q     <= 1'b0;
      tbit_q    <= 1'b0;
      tlen_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      tok_idx_q <= tok_idx_d;
      words_q   <= words_d;
      err_q     <= err_d;
      tbit_q    <= tbit_d;
      tlen_q    <= tlen_d;
    end
  end

  assign tok_rd_o    = (state_q == S_FETCH);
  assign tok_addr_o  = (state_q == S_FETCH) ? (src_q + tok_idx_q) : '0;
  assign dec_rst_o   = (state_q == S_CLEAR);
  assign dec_start_o = (state_q == S_ISSUE);
  assign dec_bit_o   = (state_q == S_ISSUE) ? tbit_q : 1'b0;
  assign dec_value_o = (state_q == S_ISSUE) ? tlen_q : '0;
  assign wr_en_o     = wr_w;
  assign wr_addr_o   = wr_w ? (dst_q + words_q) : '0;
  assign wr_data_o   = wr_w ? dec_out_i : '0;
  assign busy_o      = busy_w;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decomp_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_decomp_ctrl
// Brief   : Scoreboard bench for decomp_ctrl with token memory and an
//           LSB-first run-length decompressor model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_decomp_ctrl;

  localparam int N  = 32;
  localparam int AW = 16;
  localparam int VW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [AW-1:0] src_base, dst_base, word_count;
  logic          tok_rd;
  logic [AW-1:0] tok_addr;
  logic          tok_valid;
  logic [VW:0]   tok_data;
  logic          dec_rst, dec_start, dec_bit;
  logic [VW-1:0] dec_value;
  logic          dec_store;
  logic [N-1:0]  dec_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          busy, done, err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decomp_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .go_i(go),
    .src_base_i(src_base), .dst_base_i(dst_base), .word_count_i(word_count),
    .tok_rd_o(tok_rd), .tok_addr_o(tok_addr),
    .tok_valid_i(tok_valid), .tok_data_i(tok_data),
    .dec_rst_o(dec_rst), .dec_start_o(dec_start), .dec_bit_o(dec_bit),
    .dec_value_o(dec_value), .dec_store_i(dec_store), .dec_out_i(dec_out),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  // Token memory: answers lat cycles after the request (lat=0 is zero-wait).
  logic [VW:0]   mem [0:255];
  int            lat = 0;
  logic          p_act = 1'b0;
  int            p_cnt = 0;
  logic [AW-1:0] p_addr = '0;

  initial tok_valid = 1'b0;
  initial tok_data  = '0;

  always @(posedge clk) begin
    tok_valid <= 1'b0;
    if (tok_rd) begin
      if (lat == 0) begin
        tok_valid <= 1'b1;
        tok_data  <= mem[tok_addr[7:0]];
      end else begin
        p_act  <= 1'b1;
        p_cnt  <= lat - 1;
        p_addr <= tok_addr;
      end
    end else if (p_act) begin
      if (p_cnt == 0) begin
        tok_valid <= 1'b1;
        tok_data  <= mem[p_addr[7:0]];
        p_act     <= 1'b0;
      end else begin
        p_cnt <= p_cnt - 1;
      end
    end
  end

  // Decompressor model: runs fill from bit 0 upward; a full word is
  // presented on the cycle after the start that completed it.
  logic [N-1:0]  m_word = '0;
  int            m_pos  = 0;
  logic          m_store = 1'b0;
  logic [N-1:0]  m_out  = '0;
  logic          inj_store = 1'b0;
  logic [63:0]   m_tmp;

  assign dec_store = m_store | inj_store;
  assign dec_out   = m_out;

  always @(posedge clk) begin
    m_store <= 1'b0;
    if (dec_rst) begin
      m_word <= '0;
      m_pos  <= 0;
    end else if (dec_start) begin
      m_tmp = {32'd0, m_word};
      if (dec_bit) m_tmp = m_tmp | (((64'd1 << dec_value) - 64'd1) << m_pos);
      if (m_pos + int'(dec_value) >= N) begin
        m_store <= 1'b1;
        m_out   <= m_tmp[31:0];
        m_word  <= m_tmp[63:32];
        m_pos   <= m_pos + int'(dec_value) - N;
      end else begin
        m_word <= m_tmp[31:0];
        m_pos  <= m_pos + int'(dec_value);
      end
    end
  end

  // Scoreboard queues
  logic [AW-1:0]   q_rd[$];
  logic [AW+N-1:0] q_wr[$];
  logic            q_done[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (tok_rd) begin
        n_vec++;
        if (q_rd.size() == 0) begin
          n_err++;
          $display("FAIL tok_rd: unexpected read at %h, none required", tok_addr);
        end else begin
          logic [AW-1:0] e;
          e = q_rd.pop_front();
          if (tok_addr !== e) begin
            n_err++;
            $display("FAIL tok_addr: got %h required %h", tok_addr, e);
          end
        end
      end
      if (wr_en) begin
        n_vec++;
        if (q_wr.size() == 0) begin
          n_err++;
          $display("FAIL wr: unexpected write %h <= %h, none required", wr_addr, wr_data);
        end else begin
          logic [AW+N-1:0] e;
          e = q_wr.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_err++;
            $display("FAIL wr: got %h <= %h required %h <= %h",
                     wr_addr, wr_data, e[AW+N-1:N], e[N-1:0]);
          end
        end
      end
      if (done) begin
        n_vec++;
        if (q_done.size() == 0) begin
          n_err++;
          $display("FAIL done: unexpected done pulse");
        end else begin
          logic e;
          e = q_done.pop_front();
          if (err !== e) begin
            n_err++;
            $display("FAIL err_at_done: got %b required %b", err, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [VW:0] tk(input logic b, input int len);
    logic [VW-1:0] l;
    l = len[VW-1:0];
    return {b, l};
  endfunction

  // One transfer: checks cycles from go to done, dec_start and dec_rst counts.
  task automatic run(input string nm, input logic [AW-1:0] s, input logic [AW-1:0] d,
                     input logic [AW-1:0] wc, input int exp_cyc, input int exp_st);
    int cyc = 0;
    int st  = 0;
    int rs  = 0;
    @(negedge clk);
    go = 1'b1; src_base = s; dst_base = d; word_count = wc;
    @(negedge clk);
    go = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (dec_start) st++;
      if (dec_rst) rs++;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, cyc);
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, "_dec_start_cnt"}, 64'(st), 64'(exp_st));
    chk({nm, "_dec_rst_cnt"}, 64'(rs), 64'd1);
    #1;
    chk({nm, "_leftover_expect"}, 64'(q_rd.size() + q_wr.size() + q_done.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; go = 1'b0;
    src_base = '0; dst_base = '0; word_count = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({tok_rd, tok_addr, dec_rst, dec_start, dec_bit, dec_value, wr_en, busy, done, err}), 64'd0);
    reset = 1'b0;

    // Single full-width run
    mem[8'h10] = tk(1'b1, 32);
    q_rd.push_back(16'h0010);
    q_wr.push_back({16'h0100, 32'hFFFFFFFF});
    q_done.push_back(1'b0);
    run("t1_single", 16'h0010, 16'h0100, 16'd1, 6, 1);

    // Runs crossing a word boundary
    mem[8'h20] = tk(1'b1, 20);
    mem[8'h21] = tk(1'b0, 20);
    mem[8'h22] = tk(1'b1, 24);
    q_rd.push_back(16'h0020); q_rd.push_back(16'h0021); q_rd.push_back(16'h0022);
    q_wr.push_back({16'h0200, 32'h000FFFFF});
    q_wr.push_back({16'h0201, 32'hFFFFFF00});
    q_done.push_back(1'b0);
    run("t2_cross", 16'h0020, 16'h0200, 16'd2, 14, 3);

    // Zero-length token is skipped
    mem[8'h30] = tk(1'b1, 0);
    mem[8'h31] = tk(1'b0, 32);
    q_rd.push_back(16'h0030); q_rd.push_back(16'h0031);
    q_wr.push_back({16'h0300, 32'h00000000});
    q_done.push_back(1'b0);
    run("t3_skip", 16'h0030, 16'h0300, 16'd1, 8, 1);

    // Oversized run flags an error
    mem[8'h38] = tk(1'b1, 40);
    q_rd.push_back(16'h0038);
    q_done.push_back(1'b1);
    run("t4_err", 16'h0038, 16'h0380, 16'd1, 4, 0);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", 64'({err, busy}), 64'b10);

    // Stray store while idle must not write
    inj_store = 1'b1;
    #1;
    chk("idle_store_ignored", 64'(wr_en), 64'd0);
    @(negedge clk);
    inj_store = 1'b0;

    // Empty transfer; also clears the sticky error
    q_done.push_back(1'b0);
    run("t5_empty", 16'h0050, 16'h0500, 16'd0, 2, 0);

    // Reset while waiting on a slow token response
    begin
      logic bad;
      mem[8'h60] = tk(1'b1, 32);
      lat = 4;
      q_rd.push_back(16'h0060);
      @(negedge clk);
      go = 1'b1; src_base = 16'h0060; dst_base = 16'h0600; word_count = 16'd1;
      @(negedge clk); go = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_in_wait", 64'({busy, tok_rd}), 64'b10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t6_reset_outputs",
          64'({tok_rd, tok_addr, dec_rst, dec_start, dec_bit, dec_value, wr_en, busy, done, err}), 64'd0);
      bad = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (busy || wr_en || tok_rd || dec_start || done) bad = 1'b1;
      end
      chk("t6_late_token_ignored", 64'(bad), 64'd0);
    end
    lat = 0;
    q_rd.push_back(16'h0060);
    q_wr.push_back({16'h0600, 32'hFFFFFFFF});
    q_done.push_back(1'b0);
    run("t6_refetch", 16'h0060, 16'h0600, 16'd1, 6, 1);

    // Reset wins over go in the same cycle
    @(negedge clk);
    reset = 1'b1; go = 1'b1;
    @(negedge clk);
    reset = 1'b0; go = 1'b0;
    chk("reset_over_go", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
